calc1_port_responder: RTL and testbench

- Responder end of the calc1 request/response port protocol; one instance serves one requester port.
- Accepts two-cycle requests: command plus operand 1, then operand 2.
- Computes the 32-bit result and returns a one-cycle response code with result data after a fixed latency.
- Four instances plus a shared reset form a calc1-compatible core; benches for that core drive this block directly.

---
 rtl/calc1_port_responder.sv | 152 +++++++++++++++
 tb/tb_calc1_port_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/calc1_port_responder.sv
// calc1_port_responder: responder end of the calc1 two-cycle request/response port.
// Optional feature macro CALC1_SHIFT_EN: when defined, commands 5/6 execute as shifts.
module calc1_port_responder #(
  parameter int EXEC_LAT = 3,
  parameter int DATA_W   = 32
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic [0:3]        req_cmd_in,
  input  logic [0:DATA_W-1] req_data_in,
  output logic [0:1]        out_resp,
  output logic [0:DATA_W-1] out_data,
  output logic              out_busy
);

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
`ifdef CALC1_SHIFT_EN
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;
`endif

  localparam logic [3:0] LAT_LOAD = 4'(EXEC_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    OP2,
    EXEC,
    RESP
  } state_t;

  // Returns {resp, data}; any failing or unknown command yields {RESP_ERR, 0}.
  function automatic logic [DATA_W+1:0] execute(
    input logic [3:0]        cmd,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W:0]   wide;
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
    resp = RESP_ERR;
    data = '0;
    wide = '0;
    case (cmd)
      CMD_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        if (!wide[DATA_W]) begin
          resp = RESP_OK;
          data = wide[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (b <= a) begin
          resp = RESP_OK;
          data = a - b;
        end
      end
`ifdef CALC1_SHIFT_EN
      CMD_SHL: begin
        resp = RESP_OK;
        data = a << b[4:0];
      end
      CMD_SHR: begin
        resp = RESP_OK;
        data = a >> b[4:0];
      end
`endif
      default: ;
    endcase
    return {resp, data};
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        resp_q, resp_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= RESP_NONE;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // Response registers default to idle so RESP lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    cnt_d   = cnt_q;
    resp_d  = RESP_NONE;
    data_d  = '0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (req_cmd_in != 4'd0) begin
          cmd_d   = req_cmd_in;
          op1_d   = req_data_in;
          busy_d  = 1'b1;
          state_d = OP2;
        end
      end
      OP2: begin
        op2_d   = req_data_in;
        cnt_d   = LAT_LOAD;
        state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          {resp_d, data_d} = execute(cmd_q, op1_q, op2_q);
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_resp = resp_q;
  assign out_data = data_q;
  assign out_busy = busy_q;

endmodule

// File: tb/tb_calc1_port_responder.sv
// Directed table-driven bench for calc1_port_responder, plus busy-rejection and async-reset sequences.
module tb_calc1_port_responder;

  localparam int EXEC_LAT = 3;
  localparam int DATA_W   = 32;

  logic        clk;
  logic        rst_n;
  logic [3:0]  cmd_in;
  logic [31:0] data_in;
  logic [1:0]  resp_out;
  logic [31:0] data_out;
  logic        busy_out;

  int n_vec  = 0;
  int n_fail = 0;

  calc1_port_responder #(.EXEC_LAT(EXEC_LAT), .DATA_W(DATA_W)) dut (
    .c_clk       (clk),
    .reset_n     (rst_n),
    .req_cmd_in  (cmd_in),
    .req_data_in (data_in),
    .out_resp    (resp_out),
    .out_data    (data_out),
    .out_busy    (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  resp;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [1:0] er, input logic eb, input logic [31:0] ed);
    n_vec++;
    if (resp_out !== er || busy_out !== eb || data_out !== ed) begin
      n_fail++;
      $display("FAIL %s: got resp=%0d busy=%0b data=%h, want resp=%0d busy=%0b data=%h",
               name, resp_out, busy_out, data_out, er, eb, ed);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after busy falls.
  task automatic run_req(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] er, input logic [31:0] ed, input string name);
    cmd_in = cmd;
    data_in = a;
    @(negedge clk);
    check({name, " op1-accept"}, 2'd0, 1'b1, 32'h0);
    cmd_in = 4'hF;
    data_in = b;
    @(negedge clk);
    cmd_in = 4'h0;
    data_in = 32'h0;
    check({name, " op2-accept"}, 2'd0, 1'b1, 32'h0);
    for (int j = 1; j < EXEC_LAT; j++) begin
      @(negedge clk);
      check({name, " exec"}, 2'd0, 1'b1, 32'h0);
    end
    @(negedge clk);
    check({name, " response"}, er, 1'b1, ed);
    @(negedge clk);
    check({name, " after-resp"}, 2'd0, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{4'd1, 32'h00000001, 32'h1FFFFFFF, 2'd1, 32'h20000000, "add-carry-boundary"};
    vecs[1]  = '{4'd1, 32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h00000000, "add-overflow"};
    vecs[2]  = '{4'd1, 32'h12345678, 32'h11111111, 2'd1, 32'h23456789, "add-plain"};
    vecs[3]  = '{4'd1, 32'h80000000, 32'h7FFFFFFF, 2'd1, 32'hFFFFFFFF, "add-max"};
    vecs[4]  = '{4'd2, 32'h00000001, 32'h0000000F, 2'd2, 32'h00000000, "sub-underflow"};
    vecs[5]  = '{4'd2, 32'h0000000F, 32'h0000000F, 2'd1, 32'h00000000, "sub-equal"};
    vecs[6]  = '{4'd2, 32'h10000000, 32'h00000001, 2'd1, 32'h0FFFFFFF, "sub-borrow-chain"};
    vecs[7]  = '{4'd3, 32'h00000001, 32'h00000001, 2'd2, 32'h00000000, "invalid-3"};
    vecs[8]  = '{4'd4, 32'h00000001, 32'h00000001, 2'd2, 32'h00000000, "invalid-4"};
    vecs[9]  = '{4'd15, 32'h00000001, 32'h00000001, 2'd2, 32'h00000000, "invalid-15"};
`ifdef CALC1_SHIFT_EN
    vecs[10] = '{4'd5, 32'h00000001, 32'h00000024, 2'd1, 32'h00000010, "shl-low5"};
    vecs[11] = '{4'd6, 32'h80000000, 32'd31,       2'd1, 32'h00000001, "shr-31"};
    vecs[12] = '{4'd5, 32'hFFFFFFFF, 32'hFFFFFFE0, 2'd1, 32'hFFFFFFFF, "shl-zero-amt"};
`else
    vecs[10] = '{4'd5, 32'h00000001, 32'h00000024, 2'd2, 32'h00000000, "shl-disabled"};
    vecs[11] = '{4'd6, 32'h80000000, 32'd31,       2'd2, 32'h00000000, "shr-disabled"};
    vecs[12] = '{4'd5, 32'hFFFFFFFF, 32'hFFFFFFE0, 2'd2, 32'h00000000, "shl-disabled-2"};
`endif
    vecs[13] = '{4'd2, 32'hDEADBEEF, 32'h00000000, 2'd1, 32'hDEADBEEF, "sub-zero"};

    // Reset state, checked before any clock edge and again after a few held cycles.
    rst_n = 1'b0;
    cmd_in = 4'h0;
    data_in = 32'h0;
    #3;
    check("reset-async", 2'd0, 1'b0, 32'h0);
    cmd_in = 4'd1;
    data_in = 32'h5;
    repeat (3) @(negedge clk);
    check("reset-held", 2'd0, 1'b0, 32'h0);
    cmd_in = 4'h0;
    data_in = 32'h0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle-after-reset", 2'd0, 1'b0, 32'h0);

    // Back-to-back vectors also exercise the earliest legal accept after busy falls.
    for (int i = 0; i < 14; i++)
      run_req(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].resp, vecs[i].data, vecs[i].name);

    // Busy rejection: commands during EXEC and RESP are ignored.
    cmd_in = 4'd1;
    data_in = 32'h2;
    @(negedge clk);
    cmd_in = 4'd1;
    data_in = 32'h3;
    @(negedge clk);
    for (int j = 1; j <= EXEC_LAT; j++) begin
      check("busy-exec", 2'd0, 1'b1, 32'h0);
      cmd_in = 4'd1;
      data_in = 32'h100;
      @(negedge clk);
    end
    check("busy-response", 2'd1, 1'b1, 32'h5);
    cmd_in = 4'd1;
    data_in = 32'h100;
    @(negedge clk);
    check("busy-resp-cmd-ignored", 2'd0, 1'b0, 32'h0);
    run_req(4'd1, 32'h7, 32'h8, 2'd1, 32'hF, "accept-after-busy");
    for (int j = 0; j < EXEC_LAT + 2; j++) begin
      @(negedge clk);
      check("no-extra-response", 2'd0, 1'b0, 32'h0);
    end

    // Async reset mid-EXEC between clock edges: request discarded.
    cmd_in = 4'd1;
    data_in = 32'h11;
    @(negedge clk);
    data_in = 32'h22;
    @(negedge clk);
    cmd_in = 4'h0;
    data_in = 32'h0;
    @(posedge clk);
    #2;
    check("pre-reset-busy", 2'd0, 1'b1, 32'h0);
    rst_n = 1'b0;
    #1;
    check("midexec-reset", 2'd0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < EXEC_LAT + 3; j++) begin
      @(negedge clk);
      check("no-resp-after-reset", 2'd0, 1'b0, 32'h0);
    end
    run_req(4'd1, 32'h0, 32'h0, 2'd1, 32'h0, "add-zero-after-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
